gpr_scoreboard: RTL and testbench

- Issue-side companion to the 32x32 general register file: tracks in-flight writes to each GPR and stalls any instruction whose source or destination register is not yet safe to access.
- Sits between decode/issue and the register file.
- Counts writes issued to a register and retires them when the writeback stage presents the matching write.
- Register 0 is never tracked.

---
 rtl/gpr_scoreboard_if.sv | 30 +++
 rtl/gpr_scoreboard.sv | 76 +++++++
 tb/tb_gpr_scoreboard.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/gpr_scoreboard_if.sv
// Issue/writeback bus between decode, writeback and the GPR scoreboard.
// The master side is the pipeline and the slave side is the scoreboard.
interface gpr_scoreboard_if;
  logic       flush;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic       rs_used;
  logic       rt_used;
  logic       issue_we;
  logic [4:0] issue_rd;
  logic       issue_ready;
  logic       stall;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic [5:0] busy_regs;
  logic       underflow_err;

  modport master (
    output flush, issue_valid, issue_rs, issue_rt, rs_used, rt_used,
           issue_we, issue_rd, wb_valid, wb_rd,
    input  issue_ready, stall, busy_regs, underflow_err
  );

  modport slave (
    input  flush, issue_valid, issue_rs, issue_rt, rs_used, rt_used,
           issue_we, issue_rd, wb_valid, wb_rd,
    output issue_ready, stall, busy_regs, underflow_err
  );
endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register in-flight write counters that stall issue on RAW hazards and
// on counter saturation. Register 0 is never tracked.
module gpr_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  gpr_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [5:0]       busy_q;
  logic [5:0]       busy_nxt;
  logic             uerr_q;

  logic rs_hazard;
  logic rt_hazard;
  logic rd_full;
  logic ready;
  logic accept;
  logic retire;
  logic uf_set;

  // Hazard checks see only registered counts, so a writeback in this cycle
  // never releases a reader in the same cycle.
  assign rs_hazard = sb.rs_used && (sb.issue_rs != 5'd0) && (cnt[sb.issue_rs] != '0);
  assign rt_hazard = sb.rt_used && (sb.issue_rt != 5'd0) && (cnt[sb.issue_rt] != '0);
  assign rd_full   = sb.issue_we && (sb.issue_rd != 5'd0) && (cnt[sb.issue_rd] == CNT_MAX);
  assign ready     = !(rs_hazard || rt_hazard || rd_full);

  assign accept = sb.issue_valid && ready && sb.issue_we && (sb.issue_rd != 5'd0);
  assign retire = sb.wb_valid && (sb.wb_rd != 5'd0) && (cnt[sb.wb_rd] != '0);
  assign uf_set = !sb.flush && sb.wb_valid && (sb.wb_rd != 5'd0) && (cnt[sb.wb_rd] == '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_nxt = cnt;
    if (sb.flush) begin
      for (int i = 0; i < NREG; i++) cnt_nxt[i] = '0;
    end else begin
      // Applied in sequence so issue and retire to the same register cancel.
      if (accept) cnt_nxt[sb.issue_rd] = cnt_nxt[sb.issue_rd] + 1'b1;
      if (retire) cnt_nxt[sb.wb_rd]    = cnt_nxt[sb.wb_rd] - 1'b1;
    end
    cnt_nxt[0] = '0;
  end

  always_comb begin
    busy_nxt = '0;
    for (int i = 1; i < NREG; i++) busy_nxt = busy_nxt + 6'(cnt_nxt[i] != '0);
  end

  // NOTE: the counters are a small flop array, not a RAM, so resetting every entry is legal and cheap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
      busy_q <= '0;
      uerr_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
      cnt    <= cnt_nxt;
      busy_q <= busy_nxt;
      if (uf_set) uerr_q <= 1'b1;
    end
  end

  assign sb.issue_ready   = ready;
  assign sb.stall         = sb.issue_valid && !ready;
  assign sb.busy_regs     = busy_q;
  assign sb.underflow_err = uerr_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_gpr_scoreboard;

  typedef struct {
    string    name;
    bit       ready;
    bit       stall;
    bit [5:0] busy;
    bit       uerr;
  } exp_t;

  logic clk;
  logic rst;
  gpr_scoreboard_if sb_if ();

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  gpr_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    n_checks++;
    if (sb_if.issue_ready !== e.ready || sb_if.stall !== e.stall ||
        sb_if.busy_regs !== e.busy || sb_if.underflow_err !== e.uerr) begin
      n_errors++;
      $display("FAIL %s: got ready=%b stall=%b busy=%0d uerr=%b, expected ready=%b stall=%b busy=%0d uerr=%b",
               e.name, sb_if.issue_ready, sb_if.stall, sb_if.busy_regs, sb_if.underflow_err,
               e.ready, e.stall, e.busy, e.uerr);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) check(exp_q.pop_front());
    end
  end

  task automatic drive(input bit v, input bit [4:0] rs, input bit rsu, input bit [4:0] rt,
                       input bit rtu, input bit we, input bit [4:0] rd,
                       input bit wbv, input bit [4:0] wbrd, input bit fl);
    sb_if.issue_valid = v;
    sb_if.issue_rs    = rs;
    sb_if.rs_used     = rsu;
    sb_if.issue_rt    = rt;
    sb_if.rt_used     = rtu;
    sb_if.issue_we    = we;
    sb_if.issue_rd    = rd;
    sb_if.wb_valid    = wbv;
    sb_if.wb_rd       = wbrd;
    sb_if.flush       = fl;
  endtask

  task automatic expect_out(input string name, input bit v, input bit rdy,
                            input int busy, input bit uerr);
    exp_t e;
    e.name  = name;
    e.ready = rdy;
    e.stall = v && !rdy;
    e.busy  = 6'(busy);
    e.uerr  = uerr;
    exp_q.push_back(e);
  endtask

  // One cycle: drive just after the rising edge, then queue the expectation.
  task automatic step(input string name, input bit v, input bit [4:0] rs, input bit rsu,
                      input bit [4:0] rt, input bit rtu, input bit we, input bit [4:0] rd,
                      input bit wbv, input bit [4:0] wbrd, input bit fl,
                      input bit rdy, input int busy, input bit uerr);
    @(posedge clk);
    #1;
    drive(v, rs, rsu, rt, rtu, we, rd, wbv, wbrd, fl);
    expect_out(name, v, rdy, busy, uerr);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_out("reset_state", 1'b1, 1'b1, 0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;

    //      name            v  rs  rsu rt  rtu we  rd  wbv wbrd fl   rdy busy uerr
    step("issue_rd5",       1, 0,  0,  0,  0,  1,  5,  0,  0,   0,   1,  0,   0);
    step("read5_stall",     1, 5,  1,  0,  0,  0,  0,  0,  0,   0,   0,  1,   0);
    step("read5_wb_nobyp",  1, 5,  1,  0,  0,  0,  0,  1,  5,   0,   0,  1,   0);
    step("read5_release",   1, 5,  1,  0,  0,  0,  0,  0,  0,   0,   1,  0,   0);

    step("raw_c0_issue8",   1, 0,  0,  0,  0,  1,  8,  0,  0,   0,   1,  0,   0);
    step("raw_c1_stall",    1, 0,  0,  8,  1,  0,  0,  0,  0,   0,   0,  1,   0);
    step("raw_c2_stall",    1, 0,  0,  8,  1,  0,  0,  0,  0,   0,   0,  1,   0);
    step("raw_c3_wb_stall", 1, 0,  0,  8,  1,  0,  0,  1,  8,   0,   0,  1,   0);
    step("raw_c4_ready",    1, 0,  0,  8,  1,  0,  0,  0,  0,   0,   1,  0,   0);

    step("sat_w1",          1, 0,  0,  0,  0,  1,  9,  0,  0,   0,   1,  0,   0);
    step("sat_w2",          1, 0,  0,  0,  0,  1,  9,  0,  0,   0,   1,  1,   0);
    step("sat_w3",          1, 0,  0,  0,  0,  1,  9,  0,  0,   0,   1,  1,   0);
    step("sat_w4_stall",    1, 0,  0,  0,  0,  1,  9,  0,  0,   0,   0,  1,   0);
    step("sat_w4_wb_stall", 1, 0,  0,  0,  0,  1,  9,  1,  9,   0,   0,  1,   0);
    step("sat_w4_accept",   1, 0,  0,  0,  0,  1,  9,  0,  0,   0,   1,  1,   0);
    step("sat_drain1",      0, 0,  0,  0,  0,  0,  0,  1,  9,   0,   1,  1,   0);
    step("sat_drain2",      0, 0,  0,  0,  0,  0,  0,  1,  9,   0,   1,  1,   0);
    step("sat_drain3",      0, 0,  0,  0,  0,  0,  0,  1,  9,   0,   1,  1,   0);

    step("same_issue10",    1, 0,  0,  0,  0,  1, 10,  0,  0,   0,   1,  0,   0);
    step("same_iss_ret10",  1, 0,  0,  0,  0,  1, 10,  1, 10,   0,   1,  1,   0);
    step("diff_i11_r10",    1, 0,  0,  0,  0,  1, 11,  1, 10,   0,   1,  1,   0);
    step("read10_free",     1, 10, 1,  0,  0,  0,  0,  0,  0,   0,   1,  1,   0);
    step("read11_stall",    1, 0,  0, 11,  1,  0,  0,  0,  0,   0,   0,  1,   0);
    step("wb11",            0, 0,  0,  0,  0,  0,  0,  1, 11,   0,   1,  1,   0);

    step("reg0_issue_read", 1, 0,  1,  0,  1,  1,  0,  0,  0,   0,   1,  0,   0);
    step("wb_reg0",         0, 0,  0,  0,  0,  0,  0,  1,  0,   0,   1,  0,   0);
    step("after_wb0_noerr", 0, 0,  0,  0,  0,  0,  0,  0,  0,   0,   1,  0,   0);
    step("wb12_underflow",  0, 0,  0,  0,  0,  0,  0,  1, 12,   0,   1,  0,   0);
    step("uerr_set",        0, 0,  0,  0,  0,  0,  0,  0,  0,   0,   1,  0,   1);

    step("fl_issue3a",      1, 0,  0,  0,  0,  1,  3,  0,  0,   0,   1,  0,   1);
    step("fl_issue3b",      1, 0,  0,  0,  0,  1,  3,  0,  0,   0,   1,  1,   1);
    step("fl_issue4",       1, 0,  0,  0,  0,  1,  4,  0,  0,   0,   1,  1,   1);
    step("flush_issue6",    1, 0,  0,  0,  0,  1,  6,  0,  0,   1,   1,  2,   1);
    step("post_fl_rd3_4",   1, 3,  1,  4,  1,  0,  0,  0,  0,   0,   1,  0,   1);
    step("post_fl_rd6",     1, 6,  1,  0,  0,  0,  0,  0,  0,   0,   1,  0,   1);

    step("pre_rst_issue7",  1, 0,  0,  0,  0,  1,  7,  0,  0,   0,   1,  0,   1);
    step("pre_rst_busy",    1, 7,  1,  0,  0,  0,  0,  0,  0,   0,   0,  1,   1);

    // Reset asserted mid-cycle must clear state before the next edge.
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_out("async_rst_clear", 1'b1, 1'b1, 0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;

    step("post_rst_issue7", 1, 0,  0,  0,  0,  1,  7,  0,  0,   0,   1,  0,   0);
    step("post_rst_busy",   0, 0,  0,  0,  0,  0,  0,  0,  0,   0,   1,  1,   0);

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
